// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift unit: op codes, FSM encoding and
// the shift-count saturation helper.
package shift_pkg;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SLA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Beyond width shifts every bit has been replaced by fill, so more steps change nothing.
  function automatic int unsigned sat_count(input int unsigned n, input int unsigned width);
    return (n > width) ? width : n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate of one word. Rotate cases exist only
// when SERIAL_SHIFT_ROTATE_EN is defined; any other op code shifts right logically.
import shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] q_o
);

  always_comb begin
    q_o = {1'b0, d_i[WIDTH-1:1]};
    case (op_i)
      OP_SLL, OP_SLA: q_o = {d_i[WIDTH-2:0], 1'b0};
      OP_SRA:         q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROTATE_EN
      OP_ROR:         q_o = {d_i[0], d_i[WIDTH-1:1]};
      OP_ROL:         q_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
`endif
      default:        q_o = {1'b0, d_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shift engine: one bit per clock, valid/ready on both sides.
// Optional rotate ops are enabled by defining SERIAL_SHIFT_ROTATE_EN.
import shift_pkg::*;

module serial_shift_unit #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output state_t             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side signals must stay stable until that edge.

  // Rotates are unsaturated, so the counter must hold the full shift amount.
  localparam int CNT_W = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         op_dec;
  logic [CNT_W-1:0]   load_cnt;
  logic [WIDTH-1:0]   step_out;

  always_comb begin
    op_dec = OP_SRL;
    case (in_op)
      OP_SRL:         op_dec = OP_SRL;
      OP_SLL, OP_SLA: op_dec = OP_SLL;
      OP_SRA:         op_dec = OP_SRA;
`ifdef SERIAL_SHIFT_ROTATE_EN
      OP_ROR:         op_dec = OP_ROR;
      OP_ROL:         op_dec = OP_ROL;
`else
      OP_ROR:         op_dec = OP_SRL;
      OP_ROL:         op_dec = OP_SLL;
`endif
      default:        op_dec = OP_SRL;
    endcase
  end

  always_comb begin
    if (op_dec == OP_ROR || op_dec == OP_ROL) begin
      load_cnt = CNT_W'(in_shamt);
    end else begin
      load_cnt = CNT_W'(sat_count(32'(in_shamt), WIDTH));
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d_i  (data_q),
    .op_i (op_q),
    .q_o  (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = op_dec;
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      op_q    <= OP_SRL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed self-checking bench for serial_shift_unit (WIDTH=4, SHAMT_W=4).
// Rotate scenarios are selected by SERIAL_SHIFT_ROTATE_EN.
import shift_pkg::*;

module tb_serial_shift_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] in_shamt;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  state_t     dbg_state;

  int tests_run = 0;
  int fails     = 0;

  serial_shift_unit #(.WIDTH(4), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge with the DUT idle. Returns the result, the
  // number of edges after the accept edge until out_valid (-1 on timeout),
  // and whether in_ready stayed low from accept until the result appeared.
  task automatic run_op(input logic [3:0] a, input logic [3:0] n, input logic [2:0] op,
                        output logic [3:0] res, output int lat, output bit rdy_low);
    int cyc;
    in_data  = a;
    in_shamt = n;
    in_op    = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 0;
    rdy_low  = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (in_ready !== 1'b0) rdy_low = 1'b0;
    lat = out_valid ? cyc : -1;
    res = out_data;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0000) begin
      fails++;
      $display("FAIL reset: state=%0d out_valid=%b in_ready=%b out_data=%b, expected 0 0 1 0000",
               dbg_state, out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_srl_basic();
    logic [3:0] res;
    int lat;
    bit rl;
    run_op(4'b0011, 4'd1, 3'b000, res, lat, rl);
    tests_run++;
    if (res !== 4'b0001 || lat !== 1 || rl !== 1'b1) begin
      fails++;
      $display("FAIL srl_basic: data=%b lat=%0d rdy_low=%b, expected 0001 1 1", res, lat, rl);
    end
    release_result();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL srl_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_shift_ops();
    logic [3:0] res;
    int lat;
    bit rl;
    logic [3:0] exp_tab [4] = '{4'b0001, 4'b1000, 4'b1111, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      run_op(4'b1101, 4'd3, 3'(i), res, lat, rl);
      tests_run++;
      if (res !== exp_tab[i] || lat !== 3 || rl !== 1'b1) begin
        fails++;
        $display("FAIL shift_op%0d: data=%b lat=%0d rdy_low=%b, expected %b 3 1",
                 i, res, lat, rl, exp_tab[i]);
      end
      release_result();
    end
  endtask

  task automatic test_zero_shift();
    logic [3:0] res;
    int lat;
    bit rl;
    for (int i = 0; i < 4; i++) begin
      run_op(4'b0101, 4'd0, 3'(i), res, lat, rl);
      tests_run++;
      if (res !== 4'b0101 || lat !== 0) begin
        fails++;
        $display("FAIL zero_op%0d: data=%b lat=%0d, expected 0101 0", i, res, lat);
      end
      release_result();
    end
  endtask

  task automatic test_saturate();
    logic [3:0] res;
    int lat;
    bit rl;
    logic [2:0] op_tab  [3] = '{3'b010, 3'b000, 3'b001};
    logic [3:0] exp_tab [3] = '{4'b1111, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      run_op(4'b1000, 4'd9, op_tab[i], res, lat, rl);
      tests_run++;
      if (res !== exp_tab[i] || lat !== 4) begin
        fails++;
        $display("FAIL sat_op%0d: data=%b lat=%0d, expected %b 4", op_tab[i], res, lat, exp_tab[i]);
      end
      release_result();
    end
  endtask

  task automatic test_undefined_op();
    logic [3:0] res;
    int lat;
    bit rl;
    run_op(4'b1101, 4'd1, 3'b110, res, lat, rl);
    tests_run++;
    if (res !== 4'b0110 || lat !== 1) begin
      fails++;
      $display("FAIL undef_op110: data=%b lat=%0d, expected 0110 1", res, lat);
    end
    release_result();
    run_op(4'b1101, 4'd1, 3'b111, res, lat, rl);
    tests_run++;
    if (res !== 4'b0110 || lat !== 1) begin
      fails++;
      $display("FAIL undef_op111: data=%b lat=%0d, expected 0110 1", res, lat);
    end
    release_result();
  endtask

  task automatic test_rotate_ops();
    logic [3:0] res;
    int lat;
    bit rl;
`ifdef SERIAL_SHIFT_ROTATE_EN
    run_op(4'b1001, 4'd1, 3'b101, res, lat, rl);
    tests_run++;
    if (res !== 4'b0011 || lat !== 1) begin
      fails++;
      $display("FAIL rol1: data=%b lat=%0d, expected 0011 1", res, lat);
    end
    release_result();
    run_op(4'b1001, 4'd5, 3'b100, res, lat, rl);
    tests_run++;
    if (res !== 4'b1100 || lat !== 5) begin
      fails++;
      $display("FAIL ror5: data=%b lat=%0d, expected 1100 5", res, lat);
    end
    release_result();
    run_op(4'b1001, 4'd9, 3'b101, res, lat, rl);
    tests_run++;
    if (res !== 4'b0011 || lat !== 9) begin
      fails++;
      $display("FAIL rol9: data=%b lat=%0d, expected 0011 9", res, lat);
    end
    release_result();
`else
    run_op(4'b1101, 4'd1, 3'b100, res, lat, rl);
    tests_run++;
    if (res !== 4'b0110 || lat !== 1) begin
      fails++;
      $display("FAIL op100_as_srl: data=%b lat=%0d, expected 0110 1", res, lat);
    end
    release_result();
    run_op(4'b1101, 4'd9, 3'b101, res, lat, rl);
    tests_run++;
    if (res !== 4'b0000 || lat !== 4) begin
      fails++;
      $display("FAIL op101_as_sll: data=%b lat=%0d, expected 0000 4", res, lat);
    end
    release_result();
`endif
  endtask

  task automatic test_backpressure();
    logic [3:0] res;
    int lat;
    bit rl;
    bit stable;
    run_op(4'b1011, 4'd2, 3'b000, res, lat, rl);
    tests_run++;
    if (res !== 4'b0010 || lat !== 2) begin
      fails++;
      $display("FAIL bp_result: data=%b lat=%0d, expected 0010 2", res, lat);
    end
    in_data  = 4'b0110;
    in_shamt = 4'd0;
    in_op    = 3'b001;
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== 4'b0010 || in_ready !== 1'b0) stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold: out_valid=%b out_data=%b in_ready=%b, expected 1 0010 0",
               out_valid, out_data, in_ready);
    end
    // in_valid stays high across the exit edge; it must not be taken there.
    release_result();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL bp_no_accept_on_exit: out_valid=%b in_ready=%b state=%0d, expected 0 1 0",
               out_valid, in_ready, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 4'b0010) begin
      fails++;
      $display("FAIL bp_idle_after: out_valid=%b out_data=%b, expected 0 0010", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid_busy();
    in_data  = 4'b1101;
    in_shamt = 4'd3;
    in_op    = 3'b010;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0 || out_data !== 4'b0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: state=%0d out_valid=%b out_data=%b in_ready=%b, expected 0 0 0000 1",
               dbg_state, out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
      fails++;
      $display("FAIL reset_no_result: out_valid=%b out_data=%b, expected 0 0000", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] res;
    int lat;
    bit rl;
    run_op(4'b0110, 4'd1, 3'b001, res, lat, rl);
    release_result();
    run_op(4'b0110, 4'd2, 3'b000, res, lat, rl);
    tests_run++;
    if (res !== 4'b0001 || lat !== 2) begin
      fails++;
      $display("FAIL b2b_second: data=%b lat=%0d, expected 0001 2", res, lat);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_srl_basic();
    test_shift_ops();
    test_zero_shift();
    test_saturate();
    test_undefined_op();
    test_rotate_ops();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
